// File: rtl/alu_driver_pkg.sv
// rtl/alu_driver_pkg.sv - shared types and constants for the ALU driver
// Contents: FSM state enum, opcode constants, error codes, datapath widths,
// and the opcode legality helper used by the driver.
package alu_driver_pkg;

    localparam int OPND_W = 16;
    localparam int RES_W  = 32;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        START,
        WAIT,
        RESP
    } state_e;

    localparam logic [3:0] OP_ADD = 4'd0;
    localparam logic [3:0] OP_1   = 4'd1;
    localparam logic [3:0] OP_2   = 4'd2;
    localparam logic [3:0] OP_3   = 4'd3;
    localparam logic [3:0] OP_4   = 4'd4;
    localparam logic [3:0] OP_5   = 4'd5;
    localparam logic [3:0] OP_6   = 4'd6;

    typedef enum logic [1:0] {
        ERR_OK      = 2'b00,
        ERR_ILLEGAL = 2'b01,
        ERR_TIMEOUT = 2'b10
    } err_e;

    function automatic logic op_is_legal(input logic [3:0] op, input int num_ops);
        return 32'(op) < num_ops;
    endfunction

endpackage

// File: rtl/alu_driver_if.sv
// rtl/alu_driver_if.sv - command, ALU and response signal bundle for the ALU driver
// Groups: cmd_* (command in, cmd_ready out), alu_* (ALU control out, results in),
// res_* (captured response out, res_ready in).
// Modports: master = the driver itself, slave = the command source / ALU / response sink.
interface alu_driver_if;
    import alu_driver_pkg::*;

    logic              cmd_valid;
    logic              cmd_ready;
    logic [3:0]        cmd_op;
    logic [OPND_W-1:0] cmd_a;
    logic [OPND_W-1:0] cmd_b;
    logic              cmd_sh;
    logic [3:0]        cmd_pos;

    logic              alu_clr;
    logic              alu_bgn;
    logic [3:0]        alu_control;
    logic [3:0]        alu_pos;
    logic              alu_sh;
    logic [OPND_W-1:0] alu_nr1;
    logic [OPND_W-1:0] alu_nr2;
    logic              alu_done;
    logic [RES_W-1:0]  alu_outbus;
    logic [RES_W-1:0]  alu_neg;
    logic              alu_carry;
    logic              alu_borrow;

    logic              res_valid;
    logic              res_ready;
    logic [RES_W-1:0]  res_data;
    logic [RES_W-1:0]  res_neg;
    logic [1:0]        res_flags;
    logic [1:0]        res_err;

    modport master (
        input  cmd_valid, cmd_op, cmd_a, cmd_b, cmd_sh, cmd_pos,
        output cmd_ready,
        output alu_clr, alu_bgn, alu_control, alu_pos, alu_sh, alu_nr1, alu_nr2,
        input  alu_done, alu_outbus, alu_neg, alu_carry, alu_borrow,
        output res_valid, res_data, res_neg, res_flags, res_err,
        input  res_ready
    );

    modport slave (
        output cmd_valid, cmd_op, cmd_a, cmd_b, cmd_sh, cmd_pos,
        input  cmd_ready,
        input  alu_clr, alu_bgn, alu_control, alu_pos, alu_sh, alu_nr1, alu_nr2,
        output alu_done, alu_outbus, alu_neg, alu_carry, alu_borrow,
        input  res_valid, res_data, res_neg, res_flags, res_err,
        output res_ready
    );

endinterface

// File: rtl/alu_drv_timer.sv
// rtl/alu_drv_timer.sv - busy-cycle watchdog counter for the ALU driver
// Ports: clk, rst (async active-low), clear_i (zero the count), enable_i (count
// this cycle), expired_o (high in the TIMEOUT-th enabled cycle since clear).
module alu_drv_timer #(
    parameter int TIMEOUT = 64
) (
    input  logic clk,
    input  logic rst,
    input  logic clear_i,
    input  logic enable_i,
    output logic expired_o
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);

    logic [CNT_W-1:0] cnt_q;

    // The count holds the number of enabled cycles already completed, so the
    // TIMEOUT-th enabled cycle sees TIMEOUT-1 and reports expiry in that cycle.
    assign expired_o = enable_i && (cnt_q == CNT_W'(TIMEOUT - 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else if (clear_i) begin
            cnt_q <= '0;
        end else if (enable_i && !expired_o) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

endmodule

// File: rtl/alu_driver.sv
// rtl/alu_driver.sv - sequences one ALU operation per accepted command
// Ports: clk, rst (async active-low), bus (alu_driver_if.master: cmd_* command
// handshake, alu_* ALU control and results, res_* response handshake).
// Option: ALU_DRIVER_TIMEOUT_EN adds a busy-cycle watchdog (alu_drv_timer) that
// ends a stalled operation with res_err = ERR_TIMEOUT.
module alu_driver
    import alu_driver_pkg::*;
#(
    parameter int TIMEOUT = 64,
    parameter int NUM_OPS = 7
) (
    input  logic         clk,
    input  logic         rst,
    alu_driver_if.master bus
);

    state_e            state_q;
    logic              alu_clr_q;
    logic              alu_bgn_q;
    logic [3:0]        alu_control_q;
    logic [3:0]        alu_pos_q;
    logic              alu_sh_q;
    logic [OPND_W-1:0] alu_nr1_q;
    logic [OPND_W-1:0] alu_nr2_q;
    logic              res_valid_q;
    logic [RES_W-1:0]  res_data_q;
    logic [RES_W-1:0]  res_neg_q;
    logic [1:0]        res_flags_q;
    logic [1:0]        res_err_q;

`ifdef ALU_DRIVER_TIMEOUT_EN
    logic tmr_expired;

    // Clearing during START leaves the count at zero on the first WAIT cycle.
    alu_drv_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_timer (
        .clk       (clk),
        .rst       (rst),
        .clear_i   (state_q == START),
        .enable_i  (state_q == WAIT),
        .expired_o (tmr_expired)
    );
`else
    wire unused_timeout_cfg = |TIMEOUT;
`endif

    // Reset is folded in so ready stays low while reset is held, yet rises in
    // the very first IDLE cycle after release rather than one cycle later.
    assign bus.cmd_ready   = rst && (state_q == IDLE);

    assign bus.alu_clr     = alu_clr_q;
    assign bus.alu_bgn     = alu_bgn_q;
    assign bus.alu_control = alu_control_q;
    assign bus.alu_pos     = alu_pos_q;
    assign bus.alu_sh      = alu_sh_q;
    assign bus.alu_nr1     = alu_nr1_q;
    assign bus.alu_nr2     = alu_nr2_q;
    assign bus.res_valid   = res_valid_q;
    assign bus.res_data    = res_data_q;
    assign bus.res_neg     = res_neg_q;
    assign bus.res_flags   = res_flags_q;
    assign bus.res_err     = res_err_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= IDLE;
            alu_clr_q     <= 1'b0;
            alu_bgn_q     <= 1'b0;
            alu_control_q <= '0;
            alu_pos_q     <= '0;
            alu_sh_q      <= 1'b0;
            alu_nr1_q     <= '0;
            alu_nr2_q     <= '0;
            res_valid_q   <= 1'b0;
            res_data_q    <= '0;
            res_neg_q     <= '0;
            res_flags_q   <= '0;
            res_err_q     <= ERR_OK;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.cmd_valid) begin
                        // Operands are only rewritten here, which keeps them
                        // stable across LOAD, START and WAIT.
                        alu_control_q <= bus.cmd_op;
                        alu_pos_q     <= bus.cmd_pos;
                        alu_sh_q      <= bus.cmd_sh;
                        alu_nr1_q     <= bus.cmd_a;
                        alu_nr2_q     <= bus.cmd_b;
                        if (op_is_legal(bus.cmd_op, NUM_OPS)) begin
                            state_q   <= LOAD;
                            alu_clr_q <= 1'b1;
                            alu_bgn_q <= 1'b1;
                        end else begin
                            state_q     <= RESP;
                            res_valid_q <= 1'b1;
                            res_data_q  <= '0;
                            res_neg_q   <= '0;
                            res_flags_q <= '0;
                            res_err_q   <= ERR_ILLEGAL;
                        end
                    end
                end
                LOAD: begin
                    state_q   <= START;
                    alu_clr_q <= 1'b0;
                end
                START: begin
                    state_q   <= WAIT;
                    alu_bgn_q <= 1'b0;
                end
                WAIT: begin
                    // A result arriving on the expiry cycle still wins.
                    if (bus.alu_done) begin
                        state_q     <= RESP;
                        res_valid_q <= 1'b1;
                        res_data_q  <= bus.alu_outbus;
                        res_neg_q   <= bus.alu_neg;
                        res_flags_q <= {bus.alu_carry, bus.alu_borrow};
                        res_err_q   <= ERR_OK;
                    end
`ifdef ALU_DRIVER_TIMEOUT_EN
                    else if (tmr_expired) begin
                        state_q     <= RESP;
                        res_valid_q <= 1'b1;
                        res_data_q  <= '0;
                        res_neg_q   <= '0;
                        res_flags_q <= '0;
                        res_err_q   <= ERR_TIMEOUT;
                    end
`endif
                end
                RESP: begin
                    // Returning to IDLE first means a command offered together
                    // with res_ready waits one cycle before it is accepted.
                    if (bus.res_ready) begin
                        state_q     <= IDLE;
                        res_valid_q <= 1'b0;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_driver.sv
// tb/tb_alu_driver.sv - self-checking bench for alu_driver with a behavioural ALU model
module tb_alu_driver;
    import alu_driver_pkg::*;

    localparam int TIMEOUT = 64;
    localparam int NUM_OPS = 7;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    alu_driver_if bus();

    alu_driver #(
        .TIMEOUT (TIMEOUT),
        .NUM_OPS (NUM_OPS)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct packed {
        logic [31:0] data;
        logic [31:0] neg;
        logic [1:0]  flags;
        logic [1:0]  err;
    } resp_t;

    resp_t exp_q[$];
    resp_t e, got;
    int    ntests = 0;
    int    nfail  = 0;
    int    lat, nclr, nbgn;
    bit    seen, ok;

    // ALU behaviour: add, sub, and, mul, or, xor, optional left shift.
    function automatic logic [65:0] alu_fn(input logic [3:0] op, input logic [15:0] a,
                                           input logic [15:0] b, input logic sh, input logic [3:0] pos);
        logic [31:0] r;
        logic        c, bo;
        r = '0; c = 1'b0; bo = 1'b0;
        case (op)
            4'd0: begin r = 32'(a) + 32'(b); c = r[16]; end
            4'd1: begin r = 32'(a) - 32'(b); bo = (a < b); end
            4'd2: r = 32'(a & b);
            4'd3: r = 32'(a) * 32'(b);
            4'd4: r = 32'(a | b);
            4'd5: r = 32'(a ^ b);
            4'd6: r = sh ? (32'(a) << pos) : 32'(a);
            default: r = '0;
        endcase
        return {r, 32'(0) - r, c, bo};
    endfunction

    function automatic resp_t expect_of(input logic [3:0] op, input logic [15:0] a,
                                        input logic [15:0] b, input logic sh, input logic [3:0] pos);
        resp_t       r;
        logic [65:0] v;
        r = '0;
        if (int'(op) >= NUM_OPS) begin
            r.err = ERR_ILLEGAL;
        end else begin
            v       = alu_fn(op, a, b, sh, pos);
            r.data  = v[65:34];
            r.neg   = v[33:2];
            r.flags = v[1:0];
            r.err   = ERR_OK;
        end
        return r;
    endfunction

    // ALU model: arms on the START cycle (bgn without clr) and raises done
    // after model_delay busy cycles, or never when model_never is set.
    int          model_delay, model_cnt;
    bit          model_never, model_force, model_spur, model_armed;
    logic [65:0] model_v;

    initial begin
        model_delay = 0; model_cnt = 0;
        model_never = 0; model_force = 0; model_spur = 0; model_armed = 0;
        bus.alu_done = 1'b0; bus.alu_outbus = '0; bus.alu_neg = '0;
        bus.alu_carry = 1'b0; bus.alu_borrow = 1'b0;
        forever begin
            @(posedge clk); #1;
            bus.alu_done = 1'b0;
            if (!rst || bus.res_valid) model_armed = 0;
            if (rst && model_spur) begin
                bus.alu_done   = 1'($urandom_range(0, 1));
                bus.alu_outbus = $urandom;
                bus.alu_neg    = $urandom;
                bus.alu_carry  = 1'($urandom_range(0, 1));
                bus.alu_borrow = 1'($urandom_range(0, 1));
            end else if (model_armed) begin
                if (model_force || (!model_never && model_cnt == 0)) begin
                    model_v = alu_fn(bus.alu_control, bus.alu_nr1, bus.alu_nr2, bus.alu_sh, bus.alu_pos);
                    {bus.alu_outbus, bus.alu_neg, bus.alu_carry, bus.alu_borrow} = model_v;
                    bus.alu_done = 1'b1;
                    model_armed  = 0;
                    model_force  = 0;
                end else if (model_cnt > 0) begin
                    model_cnt--;
                end
            end else if (rst && bus.alu_bgn && !bus.alu_clr) begin
                model_armed = 1;
                model_cnt   = model_delay;
            end
        end
    end

    // Called #1 after an edge; returns #1 after the accepting edge.
    task automatic start_cmd(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                             input logic sh, input logic [3:0] pos);
        bus.cmd_valid = 1'b1; bus.cmd_op = op; bus.cmd_a = a; bus.cmd_b = b;
        bus.cmd_sh = sh; bus.cmd_pos = pos;
        ok = 0;
        for (int i = 0; i < 20 && !ok; i++) begin
            if (bus.cmd_ready) ok = 1;
            @(posedge clk); #1;
        end
        bus.cmd_valid = 1'b0;
        if (ok) exp_q.push_back(expect_of(op, a, b, sh, pos));
    endtask

    // Counts edges from acceptance to res_valid, plus clr/bgn high cycles.
    task automatic wait_resp(input int budget);
        lat = 0; nclr = 0; nbgn = 0; seen = 0;
        for (int i = 0; i < budget && !seen; i++) begin
            if (bus.res_valid) begin
                seen = 1;
            end else begin
                nclr += int'(bus.alu_clr);
                nbgn += int'(bus.alu_bgn);
                @(posedge clk); #1;
                lat++;
            end
        end
        got = {bus.res_data, bus.res_neg, bus.res_flags, bus.res_err};
    endtask

    task automatic consume();
        bus.res_ready = 1'b1;
        @(posedge clk); #1;
        bus.res_ready = 1'b0;
    endtask

    task automatic test_reset();
        bus.cmd_valid = 1'b0; bus.cmd_op = '0; bus.cmd_a = '0; bus.cmd_b = '0;
        bus.cmd_sh = 1'b0; bus.cmd_pos = '0; bus.res_ready = 1'b0;
        rst = 1'b0;
        repeat (3) @(posedge clk); #1;
        ntests++; if ({bus.cmd_ready, bus.alu_clr, bus.alu_bgn, bus.res_valid} !== 4'b0) begin
            nfail++; $display("FAIL reset_ctrl: got %b expected 0000", {bus.cmd_ready, bus.alu_clr, bus.alu_bgn, bus.res_valid}); end
        ntests++; if ({bus.alu_control, bus.alu_pos, bus.alu_sh, bus.alu_nr1, bus.alu_nr2,
                       bus.res_data, bus.res_neg, bus.res_flags, bus.res_err} !== '0) begin
            nfail++; $display("FAIL reset_data: nonzero output during reset, expected all 0"); end
        rst = 1'b1; #1;
        ntests++; if (bus.cmd_ready !== 1'b1) begin
            nfail++; $display("FAIL reset_release_ready: got %b expected 1", bus.cmd_ready); end
        @(posedge clk); #1;
    endtask

    task automatic test_basic();
        model_delay = 5;
        start_cmd(OP_ADD, 16'h000F, 16'h0003, 1'b0, 4'd0);
        ntests++; if (ok !== 1'b1) begin nfail++; $display("FAIL basic_accept: got %b expected 1", ok); end
        wait_resp(50);
        ntests++; if (seen !== 1'b1) begin nfail++; $display("FAIL basic_resp_seen: got %b expected 1", seen); end
        ntests++; if (lat !== 8) begin nfail++; $display("FAIL basic_latency: got %0d expected 8", lat); end
        ntests++; if (nclr !== 1) begin nfail++; $display("FAIL basic_clr_cycles: got %0d expected 1", nclr); end
        ntests++; if (nbgn !== 2) begin nfail++; $display("FAIL basic_bgn_cycles: got %0d expected 2", nbgn); end
        ntests++; if (bus.res_data !== 32'h12 || bus.res_err !== 2'b00) begin
            nfail++; $display("FAIL basic_result: got %h/%b expected 00000012/00", bus.res_data, bus.res_err); end
        e = exp_q.pop_front();
        ntests++; if (got !== e) begin nfail++; $display("FAIL basic_model: got %h expected %h", got, e); end
        ntests++; if (bus.cmd_ready !== 1'b0) begin nfail++; $display("FAIL basic_ready_in_resp: got %b expected 0", bus.cmd_ready); end
        consume();
        ntests++; if ({bus.res_valid, bus.cmd_ready} !== 2'b01) begin
            nfail++; $display("FAIL basic_return_idle: got %b expected 01", {bus.res_valid, bus.cmd_ready}); end
    endtask

    task automatic test_illegal();
        start_cmd(4'hA, 16'h1234, 16'h5678, 1'b1, 4'd3);
        wait_resp(10);
        ntests++; if ({seen, lat, nbgn, nclr} !== {1'b1, 32'd0, 32'd0, 32'd0}) begin
            nfail++; $display("FAIL illegal_path: got seen=%b lat=%0d bgn=%0d clr=%0d expected 1/0/0/0", seen, lat, nbgn, nclr); end
        e = exp_q.pop_front();
        ntests++; if ({bus.res_data, bus.res_err} !== {32'h0, 2'b01} || {e.data, e.err} !== {bus.res_data, bus.res_err}) begin
            nfail++; $display("FAIL illegal_result: got %h/%b expected 00000000/01", bus.res_data, bus.res_err); end
        @(posedge clk); #1;
        ntests++; if ({bus.cmd_ready, bus.alu_bgn, bus.res_valid} !== 3'b001) begin
            nfail++; $display("FAIL illegal_hold: got %b expected 001", {bus.cmd_ready, bus.alu_bgn, bus.res_valid}); end
        consume();
        ntests++; if (bus.cmd_ready !== 1'b1) begin nfail++; $display("FAIL illegal_ready_back: got %b expected 1", bus.cmd_ready); end
    endtask

    task automatic test_random();
        for (int i = 0; i < 12; i++) begin
            logic [3:0] op;
            int         d;
            bit         legal;
            op = (i % 4 == 3) ? 4'($urandom_range(7, 15)) : 4'($urandom_range(0, 6));
            d  = int'($urandom_range(0, 12));
            legal = (int'(op) < NUM_OPS);
            model_delay = d;
            start_cmd(op, 16'($urandom), 16'($urandom), 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)));
            wait_resp(60);
            e = exp_q.pop_front();
            ntests++; if (lat !== (legal ? 3 + d : 0) || nbgn !== (legal ? 2 : 0)) begin
                nfail++; $display("FAIL rand_timing[%0d] op=%0d: got lat=%0d bgn=%0d expected lat=%0d bgn=%0d",
                                  i, op, lat, nbgn, legal ? 3 + d : 0, legal ? 2 : 0); end
            if (legal) begin
                ntests++; if (got !== e) begin nfail++; $display("FAIL rand_result[%0d] op=%0d: got %h expected %h", i, op, got, e); end
            end else begin
                ntests++; if ({got.data, got.err} !== {e.data, e.err}) begin
                    nfail++; $display("FAIL rand_illegal[%0d] op=%0d: got %h/%b expected %h/%b", i, op, got.data, got.err, e.data, e.err); end
            end
            consume();
        end
    endtask

    task automatic test_back_to_back();
        model_delay = 3;
        start_cmd(OP_ADD, 16'h000F, 16'h0003, 1'b0, 4'd0);
        bus.cmd_valid = 1'b1; bus.cmd_op = OP_3; bus.cmd_a = 16'h7FFF; bus.cmd_b = 16'h0003;
        bus.cmd_sh = 1'b0; bus.cmd_pos = 4'd0;
        wait_resp(30);
        e = exp_q.pop_front();
        ntests++; if ({seen, nclr} !== {1'b1, 32'd1} || got !== e || got.data !== 32'h12) begin
            nfail++; $display("FAIL b2b_first: got seen=%b clr=%0d data=%h expected 1/1/00000012", seen, nclr, got.data); end
        ntests++; if (bus.cmd_ready !== 1'b0) begin nfail++; $display("FAIL b2b_no_overlap: got %b expected 0", bus.cmd_ready); end
        consume();
        ntests++; if ({bus.res_valid, bus.cmd_ready} !== 2'b01) begin
            nfail++; $display("FAIL b2b_not_taken_in_resp: got %b expected 01", {bus.res_valid, bus.cmd_ready}); end
        @(posedge clk); #1;
        bus.cmd_valid = 1'b0;
        exp_q.push_back(expect_of(OP_3, 16'h7FFF, 16'h0003, 1'b0, 4'd0));
        wait_resp(30);
        e = exp_q.pop_front();
        ntests++; if ({seen, lat, nclr} !== {1'b1, 32'd6, 32'd1}) begin
            nfail++; $display("FAIL b2b_second_timing: got seen=%b lat=%0d clr=%0d expected 1/6/1", seen, lat, nclr); end
        ntests++; if (got !== e || got.data !== 32'h17FFD) begin
            nfail++; $display("FAIL b2b_second_result: got %h expected %h", got, e); end
        consume();
    endtask

    task automatic test_resp_hold();
        model_delay = 2;
        start_cmd(OP_1, 16'h0100, 16'h0200, 1'b0, 4'd0);
        wait_resp(30);
        e = exp_q.pop_front();
        ntests++; if (got !== e) begin nfail++; $display("FAIL hold_initial: got %h expected %h", got, e); end
        model_spur = 1;
        bus.cmd_valid = 1'b1; bus.cmd_op = OP_2;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            got = {bus.res_data, bus.res_neg, bus.res_flags, bus.res_err};
            ntests++; if ({bus.res_valid, bus.cmd_ready} !== 2'b10 || got !== e) begin
                nfail++; $display("FAIL hold_cycle[%0d]: got valid/ready=%b resp=%h expected 10/%h",
                                  i, {bus.res_valid, bus.cmd_ready}, got, e); end
        end
        model_spur = 0;
        bus.cmd_valid = 1'b0;
        consume();
        @(posedge clk); #1;
        ntests++; if ({bus.res_valid, bus.cmd_ready} !== 2'b01) begin
            nfail++; $display("FAIL hold_release: got %b expected 01", {bus.res_valid, bus.cmd_ready}); end
    endtask

    task automatic test_timeout();
        model_never = 1;
        start_cmd(OP_ADD, 16'($urandom), 16'($urandom), 1'b0, 4'd0);
`ifdef ALU_DRIVER_TIMEOUT_EN
        wait_resp(200);
        e = exp_q.pop_front();
        ntests++; if ({seen, lat} !== {1'b1, 32'(2 + TIMEOUT)}) begin
            nfail++; $display("FAIL timeout_latency: got seen=%b lat=%0d expected 1/%0d", seen, lat, 2 + TIMEOUT); end
        ntests++; if (got !== {32'h0, 32'h0, 2'b00, 2'b10}) begin
            nfail++; $display("FAIL timeout_result: got %h expected error 10 with zero data", got); end
`else
        wait_resp(150);
        ntests++; if (seen !== 1'b0) begin nfail++; $display("FAIL no_timeout_wait: got res_valid after %0d cycles expected none", lat); end
        model_force = 1;
        wait_resp(10);
        e = exp_q.pop_front();
        ntests++; if (seen !== 1'b1 || got !== e) begin
            nfail++; $display("FAIL no_timeout_result: got seen=%b resp=%h expected 1/%h", seen, got, e); end
`endif
        model_never = 0;
        consume();
    endtask

    task automatic test_reset_mid();
        model_delay = 20;
        start_cmd(OP_5, 16'hA5A5, 16'h0F0F, 1'b0, 4'd0);
        repeat (5) @(posedge clk);
        #3 rst = 1'b0;
        #1;
        ntests++; if ({bus.cmd_ready, bus.alu_clr, bus.alu_bgn, bus.alu_control, bus.alu_pos, bus.alu_sh,
                       bus.alu_nr1, bus.alu_nr2, bus.res_valid, bus.res_data, bus.res_neg,
                       bus.res_flags, bus.res_err} !== '0) begin
            nfail++; $display("FAIL midreset_outputs: nonzero output while reset held, expected all 0"); end
        exp_q.delete();
        repeat (2) @(posedge clk); #1;
        rst = 1'b1;
        wait_resp(30);
        ntests++; if (seen !== 1'b0) begin nfail++; $display("FAIL midreset_no_resp: got res_valid after %0d cycles expected none", lat); end
        model_delay = 1;
        start_cmd(OP_2, 16'hFF00, 16'h0FF0, 1'b0, 4'd0);
        wait_resp(30);
        e = exp_q.pop_front();
        ntests++; if ({seen, lat} !== {1'b1, 32'd4} || got !== e) begin
            nfail++; $display("FAIL midreset_next_cmd: got seen=%b lat=%0d resp=%h expected 1/4/%h", seen, lat, got, e); end
        consume();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_illegal();
        test_random();
        test_back_to_back();
        test_resp_hold();
        test_timeout();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

endmodule
